// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: the Memory stage outranks Writeback, and x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
  assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    fwd_o = FWD_RF;
    if (hit_m) begin
      fwd_o = FWD_MEM;
    end else if (hit_w) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller with multi-cycle occupancy FSM, memory-wait stall and branch-flush deferral.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic [1:0]        result_src_e,
  input  logic              mc_op_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              bubble_m,
  output logic              bubble_w,
  output logic              mc_busy,
  output logic              mc_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mc_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       mwait;
  logic       lu;
  logic       mc_stall;
  logic       stall_e_raw;
  logic       br_flush;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i        (rs1_e),
    .rd_m_i        (rd_m),
    .reg_write_m_i (reg_write_m),
    .rd_w_i        (rd_w),
    .reg_write_w_i (reg_write_w),
    .fwd_o         (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i        (rs2_e),
    .rd_m_i        (rd_m),
    .reg_write_m_i (reg_write_m),
    .rd_w_i        (rd_w),
    .reg_write_w_i (reg_write_w),
    .fwd_o         (fwd_b)
  );

  assign mwait = mem_req_m && !mem_ready_m;
  assign lu    = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));

  assign mc_stall    = ((state_q == IDLE) && mc_op_e) || (state_q == BUSY);
  assign stall_e_raw = mwait || mc_stall;
  // A taken branch held in Execute only flushes on the cycle Execute advances.
  assign br_flush    = pc_src_e && !stall_e_raw;

  // Counter holds the remaining BUSY cycles; DONE is entered as it would reach 0,
  // and MC_LAT == 2 has no BUSY cycles at all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mc_op_e && !mwait) begin
          state_d = (MC_LAT == 2) ? DONE : BUSY;
          cnt_d   = MC_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!mwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    bubble_m    = 1'b0;
    bubble_w    = 1'b0;
    mc_busy     = 1'b0;
    mc_done     = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      stall_f     = mwait || mc_stall || (lu && !br_flush);
      stall_d     = stall_f;
      stall_e     = stall_e_raw;
      stall_m     = mwait;
      flush_d     = br_flush;
      flush_e     = br_flush || (lu && !mwait);
      // A held M register cannot also take a bubble, so memory wait wins.
      bubble_m    = mc_stall && !mwait;
      bubble_w    = mwait;
      mc_busy     = mc_stall;
      mc_done     = (state_q == DONE);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_f) perf_stall_q <= perf_stall_q + 32'd1;
      if (br_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc (MC_LAT = 4): expected output vectors are queued as stimulus is driven
// and compared at the falling edge of the cycle they belong to.
module tb_hazard_ctrl_mc;

  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              reg_write_e, mc_op_e, pc_src_e, reg_write_m, reg_write_w;
  logic [1:0]        result_src_e;
  logic              mem_req_m, mem_ready_m;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic              bubble_m, bubble_w, mc_busy, mc_done;

  hazard_ctrl_mc #(.REG_AW(REG_AW), .MC_LAT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .reg_write_e  (reg_write_e),
    .result_src_e (result_src_e),
    .mc_op_e      (mc_op_e),
    .pc_src_e     (pc_src_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .bubble_m     (bubble_m),
    .bubble_w     (bubble_w),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
  );

  always #5 clk = ~clk;

  // Control field order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_m, bubble_w, mc_busy, mc_done}
  localparam logic [9:0] C_QUIET  = 10'b0000000000;
  localparam logic [9:0] C_RESET  = 10'b0000110000;
  localparam logic [9:0] C_BRANCH = 10'b0000110000;
  localparam logic [9:0] C_LU     = 10'b1100010000;
  localparam logic [9:0] C_MC     = 10'b1110001010;
  localparam logic [9:0] C_DONE   = 10'b0000000001;
  localparam logic [9:0] C_MWAIT  = 10'b1111000100;
  localparam logic [9:0] C_MWDONE = 10'b1111000101;

  typedef struct {
    string       tag;
    logic [13:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [13:0] obs_vec();
    return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, bubble_m, bubble_w, mc_busy, mc_done};
  endfunction

  task automatic push(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic [9:0] ctl);
    exp_t e;
    e.tag = tag;
    e.vec = {fa, fb, ctl};
    sb.push_back(e);
  endtask

  // Compare the oldest expectation against this cycle's outputs, then move to just after the next edge.
  task automatic check_cycle();
    exp_t        e;
    logic [13:0] o;
    @(negedge clk);
    o = obs_vec();
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.vec) passed++;
      else $error("FAIL %s observed=%b expected=%b", e.tag, o, e.vec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 1'b0; result_src_e = 2'b00; mc_op_e = 1'b0; pc_src_e = 1'b0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset forces flushes and masks forwarding even with a live match.
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
    push("reset_outputs", 2'b00, 2'b00, C_RESET);
    check_cycle();
    rst = 1'b0;

    // RAW forwarding on operand A.
    rd_w = 5'd5; reg_write_w = 1'b1;
    push("fwd_a_mem_wins", 2'b10, 2'b00, C_QUIET);
    check_cycle();
    reg_write_m = 1'b0;
    push("fwd_a_wb", 2'b01, 2'b00, C_QUIET);
    check_cycle();
    reg_write_m = 1'b1; rd_m = '0; rd_w = '0;
    push("fwd_a_x0", 2'b00, 2'b00, C_QUIET);
    check_cycle();
    rs1_e = 5'd3; rd_m = 5'd3; rs2_e = 5'd9; rd_w = 5'd9;
    push("fwd_both_ops", 2'b10, 2'b01, C_QUIET);
    check_cycle();
    clear_inputs();

    // Load-use: one stall cycle, then the load has moved on.
    result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; reg_write_e = 1'b1;
    push("load_use", 2'b00, 2'b00, C_LU);
    check_cycle();
    result_src_e = 2'b00; rd_e = '0; reg_write_e = 1'b0;
    push("load_use_released", 2'b00, 2'b00, C_QUIET);
    check_cycle();
    result_src_e = 2'b01; rd_e = '0; rs1_d = '0; rs2_d = '0;
    push("load_use_x0_ignored", 2'b00, 2'b00, C_QUIET);
    check_cycle();
    clear_inputs();

    // Multi-cycle op: 1 detect + 2 BUSY + 1 DONE.
    mc_op_e = 1'b1;
    push("mc_cycle1", 2'b00, 2'b00, C_MC);
    push("mc_cycle2", 2'b00, 2'b00, C_MC);
    push("mc_cycle3", 2'b00, 2'b00, C_MC);
    push("mc_cycle4_done", 2'b00, 2'b00, C_DONE);
    repeat (4) check_cycle();
    mc_op_e = 1'b0;
    push("mc_back_idle", 2'b00, 2'b00, C_QUIET);
    check_cycle();

    // Multi-cycle op reaching DONE while data memory waits for 5 cycles.
    mc_op_e = 1'b1;
    push("mcw_cycle1", 2'b00, 2'b00, C_MC);
    push("mcw_cycle2", 2'b00, 2'b00, C_MC);
    push("mcw_cycle3", 2'b00, 2'b00, C_MC);
    repeat (3) check_cycle();
    mem_req_m = 1'b1; mem_ready_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("mcw_done_held%0d", i), 2'b00, 2'b00, C_MWDONE);
      check_cycle();
    end
    mem_ready_m = 1'b1;
    push("mcw_ready_done", 2'b00, 2'b00, C_DONE);
    check_cycle();
    mc_op_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    push("mcw_back_idle", 2'b00, 2'b00, C_QUIET);
    check_cycle();

    // Branch held by a memory wait flushes only once the wait drops.
    pc_src_e = 1'b1; mem_req_m = 1'b1;
    push("br_defer0", 2'b00, 2'b00, C_MWAIT);
    push("br_defer1", 2'b00, 2'b00, C_MWAIT);
    repeat (2) check_cycle();
    mem_ready_m = 1'b1;
    push("br_flush", 2'b00, 2'b00, C_BRANCH);
    check_cycle();
    clear_inputs();
    push("br_flush_one_cycle", 2'b00, 2'b00, C_QUIET);
    check_cycle();

    // Branch and load-use together: the flush wins and the front end is not held.
    pc_src_e = 1'b1; result_src_e = 2'b01; rd_e = 5'd7; rs1_d = 5'd7;
    push("br_beats_load_use", 2'b00, 2'b00, C_BRANCH);
    check_cycle();
    clear_inputs();

    // Reset in the middle of BUSY abandons the op with no done pulse.
    mc_op_e = 1'b1;
    push("rst_mc_cycle1", 2'b00, 2'b00, C_MC);
    push("rst_mc_cycle2", 2'b00, 2'b00, C_MC);
    repeat (2) check_cycle();
    rst = 1'b1;
    push("rst_mid_busy", 2'b00, 2'b00, C_RESET);
    check_cycle();
    rst = 1'b0; mc_op_e = 1'b0;
    push("rst_after_busy0", 2'b00, 2'b00, C_QUIET);
    push("rst_after_busy1", 2'b00, 2'b00, C_QUIET);
    repeat (2) check_cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline, the successor to the single-cycle forwarding/stall block. It adds three things the pipeline needs once a multi-cycle execute unit (MUL/DIV) and a variable-latency data memory are attached:
- a multi-cycle occupancy state machine,
- a memory wait handshake,
- branch-flush deferral under stall.

It sits beside the stage registers and drives their enable and clear lines.

## Interface
Parameters:
- REG_AW, 5, register index width; index 0 is hard-wired zero.
- MC_LAT, 4, total cycles a multi-cycle op occupies Execute; legal range 2..15.
- CNT_W, 4, width of the multi-cycle counter; must satisfy 2**CNT_W > MC_LAT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_d, rs2_d  in  REG_AW  source registers of the instruction in Decode.
- rs1_e, rs2_e, rd_e  in  REG_AW  source and destination registers in Execute.
- reg_write_e  in  1  Execute instruction writes rd.
- result_src_e  in  2  Execute result select; 2'b01 means load.
- mc_op_e  in  1  Execute holds a multi-cycle op.
- pc_src_e  in  1  branch or jump taken in Execute.
- rd_m, rd_w  in  REG_AW  destination registers in Memory and Writeback.
- reg_write_m, reg_write_w  in  1  write enables in Memory and Writeback.
- mem_req_m  in  1  Memory stage is accessing data memory.
- mem_ready_m  in  1  data memory completes the access this cycle.
- forward_a_e, forward_b_e  out  2  00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the D/E/M stage registers.
- flush_d, flush_e  out  1  clear the D and E stage registers.
- bubble_m, bubble_w  out  1  load a bubble into the M and W stage registers.
- mc_busy  out  1  multi-cycle unit is occupied.
- mc_done  out  1  multi-cycle result is valid this cycle.

## Operation
- **Forwarding (combinational, per source operand):**
  - Select 10 when reg_write_m, rd_m != 0 and rd_m == rs_e.
  - Otherwise select 01 when reg_write_w, rd_w != 0 and rd_w == rs_e.
  - Otherwise select 00.
  - The Memory stage wins when both the Memory and Writeback stages match.
- **Memory wait:** mem_req_m & !mem_ready_m defines mwait. While mwait is high:
  - stall_f, stall_d, stall_e and stall_m are all 1;
  - bubble_w = 1;
  - this condition has the highest priority.
- **Load-use hazard:** result_src_e == 01, rd_e != 0 and rd_e equals rs1_d or rs2_d defines lu. When lu is high and mwait is low, stall_f = stall_d = 1 and flush_e = 1.
- **Multi-cycle FSM**, states IDLE, BUSY, DONE:
  - IDLE → BUSY when mc_op_e & !mwait; the counter loads MC_LAT-2.
  - BUSY: the counter decrements every cycle, including during mwait. When the counter is 0 the FSM goes to DONE.
  - DONE: mc_done = 1. The FSM goes to IDLE on the first cycle with !mwait and holds DONE otherwise.
  - In IDLE with mc_op_e, and in BUSY: stall_f = stall_d = stall_e = 1, bubble_m = 1 and mc_busy = 1.
  - In DONE, stall_e is released; Execute advances in the same cycle that the FSM leaves DONE.
- **Branch:** pc_src_e & !stall_e sets flush_d = flush_e = 1. A taken branch held in Execute by a stall flushes only in the cycle Execute advances.
- **Simultaneous events:** when lu and a branch flush occur together, the branch wins: flush_d = flush_e = 1 and stall_f = stall_d = 0.
- **Reset:** while rst is high:
  - FSM = IDLE, counter = 0;
  - flush_d = flush_e = 1;
  - all stall and bubble outputs = 0, mc_busy = mc_done = 0, forward selects = 00.
- **Reset mid-operation:** reset during BUSY abandons the op; there is no mc_done pulse.

## Timing
- Forwarding, stall, flush and bubble outputs are combinational from the inputs and the registered state. There are zero cycles of latency.
- A multi-cycle op occupies Execute for exactly MC_LAT cycles when no mwait occurs: 1 IDLE detect cycle, MC_LAT-2 BUSY cycles, 1 DONE cycle.
- A load-use hazard costs exactly 1 stall cycle.
- A memory wait stalls for (cycles until mem_ready_m) cycles.
- FSM state and counter update on the rising clk edge.

## Configuration
- HAZARD_PERF_EN defined:
  - adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0];
  - perf_stall_cnt increments on every cycle with stall_f = 1;
  - perf_flush_cnt increments on every cycle with flush_d from a branch;
  - both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package hazard_pkg holds:
  - forward-select constants FWD_RF, FWD_WB, FWD_MEM;
  - RESULT_SRC_LOAD = 2'b01;
  - the mc_state_t enum (IDLE, BUSY, DONE).
- One sub-module, fwd_sel: the per-operand forwarding compare, instantiated twice.

## Test plan
- **RAW forwarding:** rs1_e = 5, rd_m = 5 with reg_write_m, rd_w = 5 with reg_write_w → forward_a_e = 10. Then clear reg_write_m → 01. Then set rd_m = rd_w = 0 → 00.
- **Load-use:** result_src_e = 01, rd_e = 7, rs2_d = 7 → stall_f = stall_d = flush_e = 1 for exactly 1 cycle.
- **Multi-cycle with MC_LAT = 4:**
  - mc_op_e raised → stall_e high for 3 cycles;
  - mc_done high in cycle 4;
  - mc_busy high for cycles 1..3.
- **Memory wait during multi-cycle:** mem_ready_m held low for 5 cycles with the FSM reaching DONE → DONE is held; stall_m and bubble_w stay 1 for 5 cycles; the FSM returns to IDLE on the cycle mem_ready_m = 1.
- **Branch deferral and priority:**
  - pc_src_e = 1 during mwait → no flush until mwait drops, then flush_d = flush_e = 1 for 1 cycle;
  - branch and load-use together → flush wins, stall_f = 0.
- **Reset mid-BUSY:** rst pulsed → mc_busy = 0 the next cycle; no mc_done pulse; flush_d = flush_e = 1 while rst is high.
